// File: rtl/lib_timer_pkg.sv
// Shared types and helpers for the library time-of-day timer.
// Time is kept as packed hour:minute; alarms pair an enable with a time.
package lib_timer_pkg;

   typedef logic [4:0] hour_t;
   typedef logic [5:0] min_t;

   typedef struct packed {
      hour_t hour;
      min_t  min;
   } tod_t;

   typedef struct packed {
      logic en;
      tod_t t;
   } alarm_t;

   localparam int MIN_PER_HOUR = 60;
   localparam int HOUR_PER_DAY = 24;

   localparam hour_t HOUR_LAST = hour_t'(HOUR_PER_DAY - 1);
   localparam min_t  MIN_LAST  = min_t'(MIN_PER_HOUR - 1);

   function automatic logic tod_valid(input tod_t t);
      return (t.hour <= HOUR_LAST) && (t.min <= MIN_LAST);
   endfunction

   // Next minute; 23:59 rolls to 00:00 so 24 and 60 are never produced.
   function automatic tod_t tod_inc(input tod_t t);
      tod_t r;
      r = t;
      if (t.min == MIN_LAST) begin
         r.min  = '0;
         r.hour = (t.hour == HOUR_LAST) ? '0 : t.hour + hour_t'(1);
      end else begin
         r.min = t.min + min_t'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/lib_tick_prescaler.sv
// Minute prescaler: down-counter that raises tick on its terminal count.
// tick is combinational so the owner advances time on the same edge the count reloads.
module lib_tick_prescaler #(
   parameter int TICKS_PER_MIN = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICKS_PER_MIN - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_TOP;
      end else if (clear || tick) begin
         cnt_q <= CNT_TOP;
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/lib_daily_timer.sv
// Time-of-day timer with software load and NUM_ALARMS alarm channels.
// Each channel pulses rst_timer once whenever the time is updated onto its value.
module lib_daily_timer
   import lib_timer_pkg::*;
#(
   parameter int TICKS_PER_MIN = 2,
   parameter int NUM_ALARMS    = 4,
   parameter int IDX_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_valid,
   input  logic [4:0]            set_hour,
   input  logic [5:0]            set_min,
   input  logic                  alarm_we,
   input  logic [IDX_W-1:0]      alarm_idx,
   input  logic                  alarm_en,
   input  logic [4:0]            alarm_hour,
   input  logic [5:0]            alarm_min,
   output logic [4:0]            hour,
   output logic [5:0]            min,
   output logic [10:0]           time_out,
   output logic                  min_pulse,
   output logic                  day_wrap,
   output logic                  set_err,
   output logic [NUM_ALARMS-1:0] rst_timer
);

   tod_t   tod_q;
   tod_t   tod_d;
   tod_t   set_tod;
   alarm_t alarm_wr;

   logic tick;
   logic set_ok;
   logic alarm_ok;
   logic advance;
   logic time_upd;
   logic wrap_d;
   logic err_d;
   logic [NUM_ALARMS-1:0] match;

   logic min_pulse_q;
   logic day_wrap_q;
   logic set_err_q;
   logic [NUM_ALARMS-1:0] rst_timer_q;

   assign set_tod.hour   = set_hour;
   assign set_tod.min    = set_min;
   assign alarm_wr.en    = alarm_en;
   assign alarm_wr.t.hour = alarm_hour;
   assign alarm_wr.t.min  = alarm_min;

   lib_tick_prescaler #(
      .TICKS_PER_MIN (TICKS_PER_MIN)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (set_ok),
      .tick  (tick)
   );

   // A valid load wins over a coincident prescaler advance.
   always_comb begin
      set_ok   = set_valid && tod_valid(set_tod);
      alarm_ok = tod_valid(alarm_wr.t);
      advance  = tick && !set_ok;
      time_upd = set_ok || advance;
      wrap_d   = advance && (tod_q.hour == HOUR_LAST) && (tod_q.min == MIN_LAST);
      err_d    = (set_valid && !set_ok) || (alarm_we && !alarm_ok);
      tod_d    = tod_q;
      if (set_ok) begin
         tod_d = set_tod;
      end else if (advance) begin
         tod_d = tod_inc(tod_q);
      end
   end

   // Channel compare uses the pre-write alarm value, so a same-edge write cannot fire.
   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
      alarm_t alarm_q;
      logic   wr_sel;

      assign wr_sel   = alarm_we && alarm_ok && (alarm_idx == IDX_W'(i));
      assign match[i] = time_upd && alarm_q.en && (alarm_q.t == tod_d);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            alarm_q <= '0;
         end else if (wr_sel) begin
            alarm_q <= alarm_wr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tod_q       <= '0;
         min_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
         set_err_q   <= 1'b0;
         rst_timer_q <= '0;
      end else begin
         tod_q       <= tod_d;
         min_pulse_q <= advance;
         day_wrap_q  <= wrap_d;
         set_err_q   <= err_d;
         rst_timer_q <= match;
      end
   end

   assign hour      = tod_q.hour;
   assign min       = tod_q.min;
   assign time_out  = {tod_q.hour, tod_q.min};
   assign min_pulse = min_pulse_q;
   assign day_wrap  = day_wrap_q;
   assign set_err   = set_err_q;
   assign rst_timer = rst_timer_q;

endmodule

// File: tb/tb_lib_daily_timer.sv
// Directed bench for lib_daily_timer with TICKS_PER_MIN=2 and four alarm channels.
module tb_lib_daily_timer;

   logic        clk;
   logic        rst_n;
   logic        set_valid;
   logic [4:0]  set_hour;
   logic [5:0]  set_min;
   logic        alarm_we;
   logic [1:0]  alarm_idx;
   logic        alarm_en;
   logic [4:0]  alarm_hour;
   logic [5:0]  alarm_min;
   logic [4:0]  hour;
   logic [5:0]  min;
   logic [10:0] time_out;
   logic        min_pulse;
   logic        day_wrap;
   logic        set_err;
   logic [3:0]  rst_timer;

   int n_vec = 0;
   int n_err = 0;

   lib_daily_timer #(
      .TICKS_PER_MIN (2),
      .NUM_ALARMS    (4),
      .IDX_W         (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_valid  (set_valid),
      .set_hour   (set_hour),
      .set_min    (set_min),
      .alarm_we   (alarm_we),
      .alarm_idx  (alarm_idx),
      .alarm_en   (alarm_en),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .hour       (hour),
      .min        (min),
      .time_out   (time_out),
      .min_pulse  (min_pulse),
      .day_wrap   (day_wrap),
      .set_err    (set_err),
      .rst_timer  (rst_timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m);
      chk({tag, ".time"}, {21'd0, time_out}, {21'd0, 5'(h), 6'(m)});
      chk({tag, ".hour"}, {27'd0, hour}, 32'(h));
      chk({tag, ".min"},  {26'd0, min},  32'(m));
   endtask

   task automatic load(input int h, input int m);
      set_valid = 1'b1;
      set_hour  = 5'(h);
      set_min   = 6'(m);
      step(1);
      set_valid = 1'b0;
   endtask

   task automatic prog(input int idx, input logic en, input int h, input int m);
      alarm_we   = 1'b1;
      alarm_idx  = 2'(idx);
      alarm_en   = en;
      alarm_hour = 5'(h);
      alarm_min  = 6'(m);
      step(1);
      alarm_we = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      set_valid  = 1'b0;
      set_hour   = '0;
      set_min    = '0;
      alarm_we   = 1'b0;
      alarm_idx  = '0;
      alarm_en   = 1'b0;
      alarm_hour = '0;
      alarm_min  = '0;
      step(2);
      chk_time("reset", 0, 0);
      chk("reset.pulse", {29'd0, min_pulse, day_wrap, set_err}, 0);
      chk("reset.rst_timer", {28'd0, rst_timer}, 0);
      rst_n = 1'b1;

      // free run: 00:01 after 2 edges, 00:02 after 4
      step(1);
      chk_time("run.e1", 0, 0);
      chk("run.e1.pulse", {31'd0, min_pulse}, 0);
      step(1);
      chk_time("run.e2", 0, 1);
      chk("run.e2.pulse", {31'd0, min_pulse}, 1);
      step(1);
      chk("run.e3.pulse", {31'd0, min_pulse}, 0);
      step(1);
      chk_time("run.e4", 0, 2);
      chk("run.e4.pulse", {31'd0, min_pulse}, 1);

      // day wrap
      load(23, 59);
      chk_time("wrap.load", 23, 59);
      chk("wrap.load.pulse", {30'd0, min_pulse, day_wrap}, 0);
      step(1);
      chk_time("wrap.e1", 23, 59);
      step(1);
      chk_time("wrap.e2", 0, 0);
      chk("wrap.e2.day_wrap", {31'd0, day_wrap}, 1);
      chk("wrap.e2.min_pulse", {31'd0, min_pulse}, 1);
      step(1);
      chk("wrap.e3.day_wrap", {31'd0, day_wrap}, 0);
      chk("wrap.e3.min_pulse", {31'd0, min_pulse}, 0);

      // ch2 alarm at 01:00
      prog(2, 1'b1, 1, 0);
      load(0, 59);
      chk("alm2.load", {28'd0, rst_timer}, 0);
      step(1);
      chk("alm2.e1", {28'd0, rst_timer}, 0);
      step(1);
      chk_time("alm2.e2", 1, 0);
      chk("alm2.e2.rst_timer", {28'd0, rst_timer}, 4'b0100);
      for (int i = 0; i < 118; i++) begin
         step(1);
         chk("alm2.quiet", {28'd0, rst_timer}, 0);
      end
      chk_time("alm2.end", 1, 59);

      // load coincident with prescaler terminal count
      step(1);
      load(5, 30);
      chk_time("coinc.load", 5, 30);
      chk("coinc.load.pulse", {31'd0, min_pulse}, 0);
      step(1);
      chk_time("coinc.e1", 5, 30);
      step(1);
      chk_time("coinc.e2", 5, 31);
      chk("coinc.e2.pulse", {31'd0, min_pulse}, 1);

      // out-of-range loads: prescaler keeps counting
      load(24, 0);
      chk("bad_h.err", {31'd0, set_err}, 1);
      chk_time("bad_h.time", 5, 31);
      step(1);
      chk("bad_h.err_clr", {31'd0, set_err}, 0);
      chk_time("bad_h.adv", 5, 32);
      chk("bad_h.adv.pulse", {31'd0, min_pulse}, 1);
      load(5, 60);
      chk("bad_m.err", {31'd0, set_err}, 1);
      chk_time("bad_m.time", 5, 32);
      step(1);
      chk_time("bad_m.adv", 5, 33);

      // invalid alarm write leaves ch2 programmed; loading 01:00 fires it
      prog(2, 1'b1, 1, 61);
      chk("bad_alm.err", {31'd0, set_err}, 1);
      load(1, 0);
      chk("bad_alm.kept", {28'd0, rst_timer}, 4'b0100);
      chk("bad_alm.err_clr", {31'd0, set_err}, 0);
      step(1);
      chk("bad_alm.once", {28'd0, rst_timer}, 0);

      // disable suppresses ch2
      prog(2, 1'b0, 1, 0);
      load(1, 0);
      chk("dis.ch2", {28'd0, rst_timer}, 0);

      // same-edge write and load use the old alarm value
      alarm_we   = 1'b1;
      alarm_idx  = 2'd1;
      alarm_en   = 1'b1;
      alarm_hour = 5'd2;
      alarm_min  = 6'd0;
      load(2, 0);
      alarm_we = 1'b0;
      chk("same.edge", {28'd0, rst_timer}, 0);
      load(2, 0);
      chk("same.after", {28'd0, rst_timer}, 4'b0010);

      // mid-operation reset clears alarms too
      prog(0, 1'b1, 0, 3);
      load(0, 2);
      chk_time("rst.pre", 0, 2);
      step(1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_time("rst.async", 0, 0);
      chk("rst.async.out", {25'd0, min_pulse, day_wrap, set_err, rst_timer}, 0);
      rst_n = 1'b1;
      step(5);
      chk_time("rst.e5", 0, 2);
      step(1);
      chk_time("rst.e6", 0, 3);
      chk("rst.e6.rst_timer", {28'd0, rst_timer}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
